// File: rtl/hdmi_pixel_packer_pkg.sv
// Shared constants for the HDMI-to-1bpp packer.
// Covers FSM encodings, luma weights and counter sizing.
package hdmi_pixel_packer_pkg;

    localparam int WORD_WIDTH          = 32;
    localparam int DEFAULT_LINE_PIXELS = 1280;
    localparam int DEFAULT_FRAME_LINES = 1280;
    localparam int LINE_WORDS          = DEFAULT_LINE_PIXELS / WORD_WIDTH;
    localparam int LINE_CNT_W          = 11;
    localparam int BIT_CNT_W           = $clog2(WORD_WIDTH);

    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    localparam logic [1:0] s_WAIT_FRAME = 2'd0;
    localparam logic [1:0] s_ACTIVE     = 2'd1;
    localparam logic [1:0] s_FLUSH      = 2'd2;
    localparam logic [1:0] s_FRAME_DONE = 2'd3;

    // Counters must be able to hold their terminal value, hence the +1.
    function automatic int cnt_width(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/hdmi_pixel_packer_luma_threshold.sv
// One registered stage: RGB -> 8-bit luma, then a combinational threshold
// compare on the registered luma so the bit is ready one edge later.
module luma_threshold
    import hdmi_pixel_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    input  logic [7:0]  threshold,
    output logic        pix_bit,
    output logic        pix_valid
);

    logic [15:0] luma_sum;
    logic [7:0]  luma_d, luma_q;
    logic        valid_d, valid_q;

    // Weights sum to 256, so the 16-bit sum never overflows and >>8 fits 8 bits.
    always_comb begin
        luma_sum = LUMA_R * {8'd0, pixel_data[23:16]}
                 + LUMA_G * {8'd0, pixel_data[15:8]}
                 + LUMA_B * {8'd0, pixel_data[7:0]};
        luma_d  = luma_sum[15:8];
        valid_d = pixel_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            luma_q  <= luma_d;
            valid_q <= valid_d;
        end
    end

    assign pix_bit   = (luma_q >= threshold);
    assign pix_valid = valid_q;

endmodule

// File: rtl/hdmi_pixel_packer.sv
// Packs thresholded luma bits MSB-first into 32-bit FIFO words, always
// emitting exactly LINE_PIXELS/WORD_WIDTH word slots per accepted line.
module hdmi_pixel_packer
    import hdmi_pixel_packer_pkg::*;
#(
    parameter int LINE_PIXELS = DEFAULT_LINE_PIXELS,
    parameter int FRAME_LINES = DEFAULT_FRAME_LINES
)
(
    input  logic                  i_clock,
    input  logic                  i_nReset,
    input  logic                  i_enable,
    input  logic [23:0]           i_pixelData,
    input  logic                  i_pixelValid,
    input  logic                  i_vSync,
    input  logic [7:0]            i_threshold,
    input  logic                  i_fifoFull,
    output logic [31:0]           o_fifoData,
    output logic                  o_fifoWrite,
    output logic                  o_overflow,
    output logic [LINE_CNT_W-1:0] o_lineCount
);

    localparam int LW         = LINE_PIXELS / WORD_WIDTH;
    localparam int PIX_CNT_W  = cnt_width(LINE_PIXELS);
    localparam int WORD_CNT_W = cnt_width(LW);

    logic pix_bit, pix_valid;

    luma_threshold u_luma (
        .clk         (i_clock),
        .rst_n       (i_nReset),
        .pixel_data  (i_pixelData),
        .pixel_valid (i_pixelValid),
        .threshold   (i_threshold),
        .pix_bit     (pix_bit),
        .pix_valid   (pix_valid)
    );

    logic [1:0]            state_d, state_q;
    logic                  vsync_d, vsync_q;
    logic [31:0]           shift_d, shift_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_d, bit_cnt_q;
    logic [PIX_CNT_W-1:0]  pix_cnt_d, pix_cnt_q;
    logic [WORD_CNT_W-1:0] word_cnt_d, word_cnt_q;
    logic [LINE_CNT_W-1:0] line_cnt_d, line_cnt_q;
    logic [31:0]           fifo_data_d, fifo_data_q;
    logic                  fifo_write_d, fifo_write_q;
    logic                  overflow_d, overflow_q;

    logic        vsync_rise, line_end, word_slot, line_done;
    logic [31:0] word_value;

    always_comb begin
        state_d      = state_q;
        vsync_d      = i_vSync;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        word_cnt_d   = word_cnt_q;
        line_cnt_d   = line_cnt_q;
        fifo_data_d  = fifo_data_q;
        fifo_write_d = 1'b0;
        overflow_d   = overflow_q;
        word_slot    = 1'b0;
        line_done    = 1'b0;
        word_value   = 32'd0;
        vsync_rise   = i_vSync & ~vsync_q;
        // pix_valid is the registered copy of i_pixelValid and still carries the last pixel.
        line_end     = pix_valid & ~i_pixelValid;

        if (vsync_rise) begin
            state_d    = i_enable ? s_ACTIVE : s_WAIT_FRAME;
            shift_d    = 32'd0;
            bit_cnt_d  = '0;
            pix_cnt_d  = '0;
            word_cnt_d = '0;
            line_cnt_d = '0;
        end else begin
            case (state_q)
                s_ACTIVE: begin
                    if (pix_valid && pix_cnt_q < PIX_CNT_W'(LINE_PIXELS)) begin
                        shift_d   = {shift_q[30:0], pix_bit};
                        pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(WORD_WIDTH - 1)) begin
                            word_slot  = 1'b1;
                            word_value = {shift_q[30:0], pix_bit};
                        end
                    end
                    if (line_end) begin
                        state_d = s_FLUSH;
                    end
                end
                s_FLUSH: begin
                    if (pix_valid) begin
                        overflow_d = 1'b1;
                    end
                    if (bit_cnt_q != '0 || word_cnt_q < WORD_CNT_W'(LW)) begin
                        word_slot  = 1'b1;
                        word_value = (bit_cnt_q != '0)
                                   ? (shift_q << (6'd32 - {1'b0, bit_cnt_q})) : 32'd0;
                        shift_d    = 32'd0;
                        bit_cnt_d  = '0;
                        line_done  = (word_cnt_q + WORD_CNT_W'(1) == WORD_CNT_W'(LW));
                    end else begin
                        line_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // A dropped word still consumes its slot so the line keeps its length.
        if (word_slot) begin
            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
            if (i_fifoFull) begin
                overflow_d = 1'b1;
            end else begin
                fifo_write_d = 1'b1;
                fifo_data_d  = word_value;
            end
        end

        if (line_done) begin
            pix_cnt_d  = '0;
            word_cnt_d = '0;
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
            state_d    = (line_cnt_q + LINE_CNT_W'(1) == LINE_CNT_W'(FRAME_LINES))
                       ? s_FRAME_DONE : s_ACTIVE;
        end
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q      <= s_WAIT_FRAME;
            vsync_q      <= 1'b0;
            shift_q      <= 32'd0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            word_cnt_q   <= '0;
            line_cnt_q   <= '0;
            fifo_data_q  <= 32'd0;
            fifo_write_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            word_cnt_q   <= word_cnt_d;
            line_cnt_q   <= line_cnt_d;
            fifo_data_q  <= fifo_data_d;
            fifo_write_q <= fifo_write_d;
            overflow_q   <= overflow_d;
        end
    end

    assign o_fifoData  = fifo_data_q;
    assign o_fifoWrite = fifo_write_q;
    assign o_overflow  = overflow_q;
    assign o_lineCount = line_cnt_q;

endmodule

// File: doc/hdmi_pixel_packer.md
# hdmi_pixel_packer

Converts the 24-bit HDMI pixel stream into the 1-bit-per-pixel, 32-pixel-per-word packets the 32-bit frame FIFO carries to the LCD output stage. It sits directly upstream of the FIFO write port. It computes luma per pixel, thresholds it, and packs bits MSB-first. Every accepted line reaches the FIFO as exactly LINE_PIXELS/WORD_WIDTH words, so the LCD side's fixed 40-words-per-line timing never slips.

## Interface
- LINE_PIXELS, 1280, active pixels per line (multiple of WORD_WIDTH)
- FRAME_LINES, 1280, lines captured per frame
- WORD_WIDTH, 32, pixels per FIFO word
- i_clock  in  1  pixel clock (HDMI clock domain); single clock
- i_nReset  in  1  asynchronous, active-low reset
- i_enable  in  1  capture enable; sampled only on vSync rising edge
- i_pixelData  in  24  {R[23:16], G[15:8], B[7:0]}
- i_pixelValid  in  1  data enable, high during active pixels
- i_vSync  in  1  active-high frame sync
- i_threshold  in  8  luma threshold; pixel bit = (Y >= i_threshold)
- i_fifoFull  in  1  FIFO full flag
- o_fifoData  out  32  packed word, pixel 0 of the word in bit 31
- o_fifoWrite  out  1  one-cycle write strobe
- o_overflow  out  1  sticky; word dropped or pixel lost
- o_lineCount  out  11  lines completed in the current frame

## Operation
- Luma: Y = (77·R + 150·G + 29·B) >> 8. Use a 16-bit unsigned intermediate; Y is 8 bits and saturation is never needed (max 255).
- States:
  - s_WAIT_FRAME (reset state).
  - s_ACTIVE.
  - s_FLUSH.
  - s_FRAME_DONE.
- s_WAIT_FRAME: on vSync rising edge with i_enable=1, go to s_ACTIVE and clear the line, pixel and word counters. Any other vSync edge leaves the block here.
- s_ACTIVE:
  - Each valid pixel shifts one bit into the shift register.
  - After the 32nd bit, load o_fifoData and strobe o_fifoWrite.
  - Pixels beyond LINE_PIXELS in a line are ignored.
  - A falling edge of i_pixelValid ends the line and moves to s_FLUSH.
- s_FLUSH:
  - A partial word is zero-padded in the low bits and written.
  - Zero words are then written one per cycle until the line holds LINE_PIXELS/WORD_WIDTH words.
  - Then o_lineCount increments. The state returns to s_ACTIVE, or goes to s_FRAME_DONE when o_lineCount reaches FRAME_LINES.
  - Valid pixels arriving during s_FLUSH are discarded and set o_overflow.
- s_FRAME_DONE: ignore pixels. vSync rising edge behaves as in s_WAIT_FRAME.
- vSync rising edge in s_ACTIVE or s_FLUSH:
  - Discard the partial word and clear all counters.
  - Re-evaluate i_enable.
  - o_overflow is not set.
- Writes while i_fifoFull=1: o_fifoWrite stays 0, the word is dropped, o_overflow is set, and the word counter still advances so line alignment holds.
- o_overflow clears only on reset.

## Timing
- Reset values:
  - o_fifoData=0, o_fifoWrite=0, o_overflow=0, o_lineCount=0.
  - State s_WAIT_FRAME; shift register and counters 0.
- Pipeline: edge k samples the pixel and registers Y. Edge k+1 compares and shifts. If that bit completes a word, o_fifoWrite is high for the cycle after edge k+1 (latency 2).
- The i_fifoFull value checked is the one present on the write edge.
- i_vSync and i_pixelValid edges are detected against a one-cycle registered copy. The state change takes effect on the edge after detection.
- Flush: one word per cycle. Worst case is LINE_PIXELS/WORD_WIDTH cycles (a 1-pixel line pads the first word, then 39 zero words).
- Back-to-back words every 32 cycles, with no bubbles.

## Structure
- Package hdmi_pixel_packer_pkg holds:
  - State encodings.
  - Luma coefficients (77/150/29).
  - Derived constant LINE_WORDS = LINE_PIXELS/WORD_WIDTH.
  - Counter widths, via clog2 of LINE_PIXELS, LINE_WORDS and FRAME_LINES.
- Sub-module luma_threshold: a registered RGB→Y multiply-add plus compare, producing a 1-bit pixel and its valid. The packer FSM and counters stay in the top.

## Test plan
- Enabled frame; 1280 pixels per line, all 0xFFFFFF; threshold 0x80 → 40 words of 0xFFFFFFFF per line, with o_lineCount stepping 1..1280 and then s_FRAME_DONE.
- Alternating pixels 0xFFFFFF/0x000000 starting with white → every word is 0xAAAAAAAA; first strobe 2 cycles after the 32nd pixel.
- Line of 40 pixels, all white → words 0xFFFFFFFF, 0xFF000000, then 38 words of 0x00000000 (40 total).
- i_fifoFull held high for word 5 of a line → that write is suppressed, o_overflow=1 permanently, and the line still totals 40 word slots.
- vSync rising mid-line after 20 pixels → no write of the partial word, o_lineCount=0, and the next line starts at bit 31.
- i_enable=0 at vSync → no writes for the whole frame; with enable=1 at the following vSync, capture resumes.
